// File: rtl/eth_rx_mac_filter.sv
// Destination-MAC filter on the MAC rx byte stream; define ETH_RX_FILTER_STATS_EN for accept/drop/runt counters.
// Latency: first output byte 2 cycles after the 6th header beat, then up to 1 byte/cycle (input gaps compressed).
// Backpressure: none on either side; rejected frames and runts are rewound out of the byte FIFO.
module eth_rx_mac_filter #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic [47:0] cfg_mac_addr,
    input  logic        cfg_promisc,
    input  logic        cfg_bcast_en,
    input  logic        cfg_mcast_en,
`ifdef ETH_RX_FILTER_STATS_EN
    output logic [31:0] stat_rx_accept,
    output logic [31:0] stat_rx_drop,
    output logic [31:0] stat_rx_runt,
`endif
    output logic        frame_drop,
    output logic        frame_runt
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PASS,
        DROP
    } state_t;

    state_t                state;
    logic [2:0]            hdr_cnt;
    logic [39:0]           dst_hi;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] commit_ptr;
    logic [ADDR_WIDTH-1:0] frame_ptr;
    logic [9:0]            mem [DEPTH];

    logic [47:0]           dst_next;
    logic                  dst_bcast;
    logic                  accept;
    logic                  hdr_beat;
    logic                  sixth;
    logic                  accept_now;
    logic                  reject_now;
    logic                  runt;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] frame_base;

    // The 6th byte is compared combinationally so the decision lands on the same edge it is written.
    assign dst_next   = {dst_hi, s_axis_tdata};
    assign dst_bcast  = &dst_next;
    assign accept     = cfg_promisc
                      | (dst_next == cfg_mac_addr)
                      | (cfg_bcast_en & dst_bcast)
                      | (cfg_mcast_en & dst_next[40] & ~dst_bcast);

    assign hdr_beat   = s_axis_tvalid && (state == IDLE || state == HDR);
    assign sixth      = s_axis_tvalid && (state == HDR) && (hdr_cnt == 3'd5);
    assign accept_now = sixth && accept;
    assign reject_now = sixth && !accept;
    assign runt       = hdr_beat && s_axis_tlast && !sixth;
    assign wr_en      = s_axis_tvalid && (state != DROP);
    assign frame_base = (state == IDLE) ? wr_ptr : frame_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hdr_cnt    <= 3'd0;
            dst_hi     <= 40'd0;
            wr_ptr     <= '0;
            frame_ptr  <= '0;
            commit_ptr <= '0;
            frame_drop <= 1'b0;
            frame_runt <= 1'b0;
        end else begin
            frame_drop <= reject_now || runt;
            frame_runt <= runt;

            if (hdr_beat) begin
                dst_hi <= dst_next[39:0];
            end
            if (state == IDLE && s_axis_tvalid) begin
                frame_ptr <= wr_ptr;
            end

            if (reject_now || runt) begin
                wr_ptr <= frame_base;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (accept_now || (state == PASS && s_axis_tvalid)) begin
                commit_ptr <= wr_ptr + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (s_axis_tvalid) begin
                        if (s_axis_tlast) begin
                            state   <= IDLE;
                            hdr_cnt <= 3'd0;
                        end else begin
                            state   <= HDR;
                            hdr_cnt <= 3'd1;
                        end
                    end
                end
                HDR: begin
                    if (s_axis_tvalid) begin
                        if (sixth) begin
                            hdr_cnt <= 3'd0;
                            // A 6-byte frame ends here: decided like any other, but nothing follows.
                            if (s_axis_tlast) begin
                                state <= IDLE;
                            end else if (accept) begin
                                state <= PASS;
                            end else begin
                                state <= DROP;
                            end
                        end else if (s_axis_tlast) begin
                            hdr_cnt <= 3'd0;
                            state   <= IDLE;
                        end else begin
                            hdr_cnt <= hdr_cnt + 3'd1;
                        end
                    end
                end
                PASS, DROP: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= '0;
            m_axis_tdata  <= 8'd0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (rd_ptr != commit_ptr) begin
            {m_axis_tuser, m_axis_tlast, m_axis_tdata} <= mem[rd_ptr];
            m_axis_tvalid <= 1'b1;
            rd_ptr        <= rd_ptr + 1'b1;
        end else begin
            m_axis_tdata  <= 8'd0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end
    end

`ifdef ETH_RX_FILTER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rx_accept <= 32'd0;
            stat_rx_drop   <= 32'd0;
            stat_rx_runt   <= 32'd0;
        end else begin
            if (accept_now) begin
                stat_rx_accept <= stat_rx_accept + 32'd1;
            end
            if (reject_now || runt) begin
                stat_rx_drop <= stat_rx_drop + 32'd1;
            end
            if (runt) begin
                stat_rx_runt <= stat_rx_runt + 32'd1;
            end
        end
    end
`endif

endmodule
